m68k_bus_region_controller: RTL

//  Parametrised, registered successor to the combinational address decoder. Base/mask windows for NUM_REGIONS regions.

---
 rtl/m68k_bus_pkg.sv | 43 ++++
 rtl/m68k_bus_region_controller_if.sv | 23 ++
 rtl/m68k_region_match.sv | 35 +++
 rtl/m68k_bus_region_controller.sv | 123 ++++++++++++
 4 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared types, default decode map and slice helper for the 68k bus region controller.
package m68k_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    ACK     = 3'd2,
    TIMEOUT = 3'd3,
    BERR    = 3'd4
  } stateT;

  localparam int unsigned DEFAULT_ADDR_W      = 32;
  localparam int unsigned DEFAULT_NUM_REGIONS = 4;
  localparam int unsigned DEFAULT_TIMEOUT     = 16;
  localparam int unsigned WAIT_W              = 4;
  localparam int unsigned IDX_W               = 4;

  // Widest packed region vector the slice helper accepts (16 regions x 64-bit addresses).
  localparam int unsigned SLICE_VEC_W = 1024;
  localparam int unsigned SLICE_OUT_W = 64;

  // Region i lives at slice i: ROM(0), IO(1), DRAM(2), SRAM(3).
  localparam logic [127:0] DEFAULT_REGION_BASE =
    {32'hF000_0000, 32'h0800_0000, 32'h0040_0000, 32'h0000_0000};
  localparam logic [127:0] DEFAULT_REGION_MASK =
    {32'hFFFC_0000, 32'hFC00_0000, 32'hFFFF_0000, 32'hFFFF_8000};
  localparam logic [15:0]  DEFAULT_REGION_WAIT =
    {4'd1, 4'd2, 4'd3, 4'd0};

  // Extract slice idx of the given width from a packed per-region vector.
  function automatic logic [SLICE_OUT_W-1:0] regionSlice(
    input logic [SLICE_VEC_W-1:0] vec,
    input int unsigned            idx,
    input int unsigned            width
  );
    logic [SLICE_VEC_W-1:0] shifted;
    logic [SLICE_OUT_W-1:0] fieldMask;
    shifted   = vec >> (idx * width);
    fieldMask = (SLICE_OUT_W'(1) << width) - SLICE_OUT_W'(1);
    return SLICE_OUT_W'(shifted) & fieldMask;
  endfunction

endpackage

// File: rtl/m68k_bus_region_controller_if.sv
// 68k bus cycle signals between the CPU core and the region controller.
interface m68k_bus_region_controller_if #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned NUM_REGIONS = 4
);
  logic [ADDR_W-1:0]      Address;
  logic                   AS_L;
  logic [NUM_REGIONS-1:0] Select_H;
  logic [3:0]             HitIndex;
  logic                   Dtack_L;
  logic                   Berr_L;
  logic                   Busy_H;

  modport master (
    output Address, AS_L,
    input  Select_H, HitIndex, Dtack_L, Berr_L, Busy_H
  );

  modport slave (
    input  Address, AS_L,
    output Select_H, HitIndex, Dtack_L, Berr_L, Busy_H
  );
endinterface

// File: rtl/m68k_region_match.sv
// Combinational base/mask priority matcher; lowest matching region index wins.
module m68k_region_match
  import m68k_bus_pkg::*;
#(
  parameter int unsigned                    ADDR_W      = DEFAULT_ADDR_W,
  parameter int unsigned                    NUM_REGIONS = DEFAULT_NUM_REGIONS,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_BASE = DEFAULT_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_MASK = DEFAULT_REGION_MASK
) (
  input  logic [ADDR_W-1:0] Address,
  output logic              Hit,
  output logic [IDX_W-1:0]  Idx
);

  logic [NUM_REGIONS-1:0] hitVec;

  // Per-region window compare.
  always_comb begin
    hitVec = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      hitVec[i] = (Address & ADDR_W'(regionSlice(SLICE_VEC_W'(REGION_MASK), i, ADDR_W)))
                  == ADDR_W'(regionSlice(SLICE_VEC_W'(REGION_BASE), i, ADDR_W));
    end
  end

  // Priority encode, scanning high to low so the lowest hit is left standing.
  always_comb begin
    Hit = |hitVec;
    Idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hitVec[i]) Idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/m68k_bus_region_controller.sv
// Registered 68k region decoder: latches a one-hot select, counts wait states,
// acknowledges with DTACK, and raises BERR on unmapped accesses after a timeout.
module m68k_bus_region_controller
  import m68k_bus_pkg::*;
#(
  parameter int unsigned                    ADDR_W         = DEFAULT_ADDR_W,
  parameter int unsigned                    NUM_REGIONS    = DEFAULT_NUM_REGIONS,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_BASE    = DEFAULT_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_MASK    = DEFAULT_REGION_MASK,
  parameter logic [NUM_REGIONS*WAIT_W-1:0]  REGION_WAIT    = DEFAULT_REGION_WAIT,
  parameter int unsigned                    TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                          Clk,
  input  logic                          Reset_H,
  m68k_bus_region_controller_if.slave   bus
);

  // One counter shared by wait states and the timeout, sized for the larger.
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CNT_W = (TO_W > WAIT_W) ? TO_W : WAIT_W;

  stateT                  stateQ, stateD;
  logic [CNT_W-1:0]       cntQ, cntD;
  logic [NUM_REGIONS-1:0] selectQ, selectD;
  logic [IDX_W-1:0]       idxQ, idxD;
  logic                   dtackLQ, dtackLD;
  logic                   berrLQ, berrLD;
  logic                   busyQ, busyD;

  logic                   matchHit;
  logic [IDX_W-1:0]       matchIdx;

  m68k_region_match #(
    .ADDR_W      (ADDR_W),
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) uMatch (
    .Address (bus.Address),
    .Hit     (matchHit),
    .Idx     (matchIdx)
  );

  // State, counter and output registers.
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      stateQ  <= IDLE;
      cntQ    <= '0;
      selectQ <= '0;
      idxQ    <= '0;
      dtackLQ <= 1'b1;
      berrLQ  <= 1'b1;
      busyQ   <= 1'b0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      selectQ <= selectD;
      idxQ    <= idxD;
      dtackLQ <= dtackLD;
      berrLQ  <= berrLD;
      busyQ   <= busyD;
    end
  end

  // Next state, counter and next registered output values.
  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    selectD = selectQ;
    idxD    = idxQ;

    unique case (stateQ)
      IDLE: begin
        if (!bus.AS_L) begin
          if (matchHit) begin
            stateD  = WAIT;
            selectD = NUM_REGIONS'(1) << matchIdx;
            idxD    = matchIdx;
            cntD    = CNT_W'(regionSlice(SLICE_VEC_W'(REGION_WAIT), matchIdx, WAIT_W));
          end else begin
            stateD  = TIMEOUT;
            cntD    = CNT_W'(TIMEOUT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (bus.AS_L)          stateD = IDLE;
        else if (cntQ == '0)   stateD = ACK;
        else                   cntD   = cntQ - CNT_W'(1);
      end
      ACK: begin
        if (bus.AS_L) stateD = IDLE;
      end
      TIMEOUT: begin
        if (bus.AS_L)          stateD = IDLE;
        else if (cntQ == '0)   stateD = BERR;
        else                   cntD   = cntQ - CNT_W'(1);
      end
      BERR: begin
        if (bus.AS_L) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase

    // Leaving a cycle (completed or aborted) drops the select and clears the counter.
    if (stateD == IDLE) begin
      selectD = '0;
      idxD    = '0;
      cntD    = '0;
    end

    dtackLD = (stateD != ACK);
    berrLD  = (stateD != BERR);
    busyD   = (stateD != IDLE);
  end

  assign bus.Select_H = selectQ;
  assign bus.HitIndex = idxQ;
  assign bus.Dtack_L  = dtackLQ;
  assign bus.Berr_L   = berrLQ;
  assign bus.Busy_H   = busyQ;

endmodule
